// File: rtl/uart_rx_fifo_if.sv
// Byte stream handshake between the UART receiver side and the host read side.
// The FIFO takes the slave view; the environment driving it takes the master view.
interface uart_rx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;

  modport master (output wr_valid, wr_data, rd_ready, input rd_valid, rd_data);
  modport slave  (input wr_valid, wr_data, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO (first-word-fall-through) with overrun, level threshold and
// character-timeout flags; the timeout is measured in receiver sample ticks.
//
// Timeout FSM states:
//   state     | meaning
//   EMPTY     | FIFO empty, idle counter held at 0
//   COUNTING  | data waiting, idle counter below the timeout limit
//   TIMED_OUT | idle counter saturated at the limit, timeout asserted
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int SAMPLE_RATE   = 24,
  parameter int TIMEOUT_CHARS = 4,
  parameter int THRESHOLD     = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   clk_en,
  uart_rx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic                   level_irq,
  output logic                   timeout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int TICKS = TIMEOUT_CHARS * 10 * SAMPLE_RATE;
  localparam int CW    = $clog2(TICKS + 1);

  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L  = LW'(THRESHOLD);
  localparam logic [CW-1:0] TICKS_C   = CW'(TICKS);

  typedef enum logic [1:0] {EMPTY, COUNTING, TIMED_OUT} tmo_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push;
  logic          pop;
  logic          drop;

  tmo_state_t    state;
  tmo_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign bus.rd_valid = (level != '0);
  assign bus.rd_data  = mem[rd_ptr];
  assign full         = (level == DEPTH_L);
  assign level_irq    = (level >= THRESH_L);
  assign timeout      = (state == TIMED_OUT);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop  = bus.rd_valid && bus.rd_ready;
  assign push = bus.wr_valid && (!full || pop);
  assign drop = bus.wr_valid && full && !pop;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Dropped bytes are not activity: only accepted pushes and pops restart the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (push || pop) begin
      cnt_nxt   = '0;
      state_nxt = (level_nxt == '0) ? EMPTY : COUNTING;
    end else if (level == '0) begin
      cnt_nxt   = '0;
      state_nxt = EMPTY;
    end else if (clk_en && (cnt != TICKS_C)) begin
      cnt_nxt   = cnt + 1'b1;
      state_nxt = (cnt_nxt == TICKS_C) ? TIMED_OUT : COUNTING;
    end else begin
      state_nxt = (cnt == TICKS_C) ? TIMED_OUT : COUNTING;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH     = 16;
  localparam int THRESHOLD = 8;
  localparam int TICKS     = 4 * 10 * 24;

  logic       clk = 1'b0;
  logic       rstb;
  logic       clk_en;
  logic       clr_overrun;
  logic [4:0] level;
  logic       full;
  logic       overrun;
  logic       level_irq;
  logic       timeout;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .SAMPLE_RATE(24), .TIMEOUT_CHARS(4), .THRESHOLD(THRESHOLD)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .clk_en      (clk_en),
    .bus         (bus),
    .level       (level),
    .full        (full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .level_irq   (level_irq),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  string      phase  = "reset";
  logic [7:0] q [$];
  bit         ovr_m;
  int         idle_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovr_m  = 1'b0;
    idle_m = 0;
  endtask

  // Reference behaviour for one clock edge, applied to the pre-edge model state.
  task automatic model_edge(input logic wv, input logic [7:0] wd, input logic rr,
                            input logic ce, input logic clr);
    bit was_full = (q.size() == DEPTH);
    bit do_pop   = (q.size() != 0) && rr;
    bit do_push  = wv && (!was_full || do_pop);
    bit do_drop  = wv && was_full && !do_pop;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(wd);
    if (do_drop)   ovr_m = 1'b1;
    else if (clr)  ovr_m = 1'b0;
    if (do_push || do_pop || q.size() == 0) idle_m = 0;
    else if (ce && idle_m < TICKS)          idle_m++;
  endtask

  task automatic check_all();
    chk("level", level, q.size());
    chk("rd_valid", bus.rd_valid, q.size() != 0);
    if (q.size() != 0) chk("rd_data", bus.rd_data, q[0]);
    chk("full", full, q.size() == DEPTH);
    chk("level_irq", level_irq, q.size() >= THRESHOLD);
    chk("overrun", overrun, ovr_m);
    chk("timeout", timeout, (idle_m == TICKS) && (q.size() != 0));
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                      input logic ce, input logic clr);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    clk_en       = ce;
    clr_overrun  = clr;
    @(posedge clk);
    model_edge(wv, wd, rr, ce, clr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic ce);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, ce, 1'b0);
  endtask

  initial begin
    logic [7:0] seq3 [3];
    seq3 = '{8'h55, 8'hA3, 8'h0F};
    rstb         = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;
    clk_en       = 1'b0;
    clr_overrun  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rstb = 1'b1;
    idle(2, 1'b1);

    phase = "three_bytes";
    for (int i = 0; i < 3; i++) step(1'b1, seq3[i], 1'b0, 1'b0, 1'b0);
    chk("level3", level, 3);
    chk("head55", bus.rd_data, 8'h55);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained", bus.rd_valid, 1'b0);

    phase = "overflow";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    chk("full16", full, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("overrun_set", overrun, 1'b1);
    chk("level_kept", level, DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("overrun_clr", overrun, 1'b0);

    phase = "full_push_pop";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("level16", level, DEPTH);
    chk("no_overrun", overrun, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    phase = "timeout";
    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    idle(TICKS - 1, 1'b1);
    chk("not_yet", timeout, 1'b0);
    idle(1, 1'b1);
    chk("asserted", timeout, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("cleared", timeout, 1'b0);
    idle(5, 1'b1);

    phase = "empty_push_pop";
    step(1'b1, 8'hC5, 1'b1, 1'b1, 1'b0);
    chk("level1", level, 1);
    chk("valid1", bus.rd_valid, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    phase = "random_busy";
    for (int i = 0; i < 800; i++) begin
      int rr_div = (i < 400) ? 6 : 2;
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % rr_div) == 0,
           ($urandom % 2) == 0, ($urandom % 40) == 0);
    end

    phase = "random_sparse";
    for (int i = 0; i < 2400; i++)
      step(($urandom % 350) == 0, 8'($urandom), ($urandom % 500) == 0,
           ($urandom % 4) != 0, 1'b0);

    phase = "async_reset";
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #2;
    rstb = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rstb = 1'b1;
    idle(3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Buffering stage directly downstream of the UART receive deserializer. Captures each received byte on its one-cycle valid pulse and stores it in a DEPTH-entry FIFO.
- Presents bytes to the host/bus side on a first-word-fall-through valid/ready interface.
- Flags overrun, a fill-level threshold, and a character-timeout condition (FIFO non-empty, no push or pop for TIMEOUT_CHARS character times), with time measured in sample ticks of the shared clk_en.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- SAMPLE_RATE, 24, clk_en ticks per UART bit; must match the receiver's setting.
- TIMEOUT_CHARS, 4, idle character times (10 bits each) before timeout asserts; 1..15.
- THRESHOLD, 8, level at or above which level_irq asserts; 1..DEPTH.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- clk_en  in  1  sample tick, same enable that drives the receiver.
- wr_valid  in  1  one-cycle byte-received pulse from the receiver.
- wr_data  in  8  received byte; sampled only when wr_valid=1.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_valid  out  1  FIFO non-empty; rd_data is meaningful.
- rd_data  out  8  oldest stored byte.
- level  out  clog2(DEPTH)+1  current entry count, 0..DEPTH.
- full  out  1  level==DEPTH.
- overrun  out  1  sticky: a byte was dropped.
- clr_overrun  in  1  clears overrun.
- level_irq  out  1  level>=THRESHOLD.
- timeout  out  1  character-timeout flag (level).

Behaviour:
- Reset (rstb low, async): pointers=0, level=0, rd_valid=0, full=0, overrun=0, level_irq=0, timeout=0, timeout counter=0. rd_data is don't-care.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored bytes.
- Storage: pointers wr_ptr and rd_ptr, clog2(DEPTH) bits, wrap modulo DEPTH. level is a registered counter.
- Push: wr_valid=1 and (!full or pop this cycle). Write mem[wr_ptr], wr_ptr+1.
- Pop: rd_valid=1 and rd_ready=1. rd_ptr+1.
- rd_valid=(level!=0) and rd_data=mem[rd_ptr] are combinational from registers (FWFT).
  - A pushed byte is visible on rd_data the cycle after the push edge.
  - Latency wr_valid to rd_valid is 1 clock.
- Simultaneous push and pop:
  - Both happen; level is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, no pop occurs (rd_valid=0); push only.
- Overflow: wr_valid=1, full=1, no pop. Byte is dropped; memory, pointers and level are untouched; overrun<=1.
- overrun: clr_overrun=1 clears it next edge. If a drop and clr_overrun coincide, set wins.
- Underflow: rd_ready with rd_valid=0 is ignored.
- level_irq and full are combinational from level.
- Timeout:
  - TIMEOUT_TICKS = TIMEOUT_CHARS*10*SAMPLE_RATE (default 960). The counter is wide enough to hold TIMEOUT_TICKS and saturates there.
  - The counter resets to 0 on any push, any pop, or while level==0.
  - Otherwise it increments on each clk_en=1 cycle.
  - timeout=1 when counter==TIMEOUT_TICKS and level!=0. It is registered: it rises on the edge at which the counter reaches TIMEOUT_TICKS.
  - A push or pop clears timeout the next cycle. A dropped (overflow) byte does not reset the counter.
- clk_en affects only the timeout counter; FIFO push/pop operate every clk.
- State summary for the timeout FSM:
  - EMPTY (level==0): counter held at 0.
  - COUNTING: counter < TIMEOUT_TICKS, no activity.
  - TIMED_OUT: counter saturated, timeout=1.
  - Any push or pop moves to COUNTING (or EMPTY if level becomes 0).

Test Plan:
- Reset, then 3 pushes 0x55,0xA3,0x0F with rd_ready=0 -> level=3, rd_valid=1, rd_data=0x55. Then rd_ready=1 for 3 cycles -> outputs 0x55,0xA3,0x0F in order, level=0, rd_valid=0.
- DEPTH=16: push 16 bytes 0x00..0x0F -> full=1, level_irq asserted since level 8. Push 17th byte 0xEE -> dropped, overrun=1. Drain -> 0x00..0x0F, no 0xEE. Pulse clr_overrun -> overrun=0.
- Full FIFO, push 0x77 and pop in the same cycle -> level stays 16, overrun stays 0, 0x77 read out last.
- Push one byte, clk_en every cycle, no reads -> timeout=1 exactly 960 clk_en ticks after the push. Pop -> timeout=0 next cycle, level=0, counter held.
- Push 5 bytes so wr_ptr wraps past 15 after prior traffic, assert rstb low mid-stream -> level=0, rd_valid=0, overrun=0, timeout=0 immediately (asynchronous).
- Empty FIFO with wr_valid and rd_ready high together -> push only, level=1, rd_valid=1 next cycle, no spurious pop.
